// File: rtl/ps2_key_filter.sv
// ---------------------------------------------------------------------------
// ps2_key_filter
// Sits between the PS/2 receiver and the control FSM. It tracks make, break
// (F0) and extended (E0) prefixes, suppresses typematic repeats of the held
// key, and emits a one-cycle pulse for each new press of a key in KEY_TABLE.
// A separate one-cycle reset request is raised for RST_CODE.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   rx_done_tick_i in   one-cycle strobe: rx_data_i holds a new scancode byte
//   rx_data_i      in   [7:0] scancode byte
//   key_valid_o    out  one-cycle pulse: accepted key press
//   key_code_o     out  [7:0] accepted make code, 0 when key_valid_o=0
//   key_index_o    out  [3:0] table index of key_code_o, 0 when key_valid_o=0
//   rst_req_o      out  one-cycle pulse: RST_CODE make received
// ---------------------------------------------------------------------------
module ps2_key_filter #(
    parameter int unsigned           N_KEYS          = 6,
    parameter logic [8*N_KEYS-1:0]   KEY_TABLE       = {8'h21, 8'h6C, 8'h73, 8'h7A, 8'h72, 8'h70},
    parameter logic [7:0]            RST_CODE        = 8'h2D,
    parameter logic [7:0]            BRK_CODE        = 8'hF0,
    parameter logic [7:0]            EXT_CODE        = 8'hE0,
    parameter bit                    REPEAT_SUPPRESS = 1'b1,
    parameter int unsigned           TIMEOUT_CYC     = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_data_i,
    output logic       key_valid_o,
    output logic [7:0] key_code_o,
    output logic [3:0] key_index_o,
    output logic       rst_req_o
);

    // Timer only needs to reach TIMEOUT_CYC-1
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             held_valid_q, held_valid_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       key_code_q, key_code_d;
    logic [3:0]       key_index_q, key_index_d;
    logic             rst_req_q, rst_req_d;

    logic             match_hit_c;
    logic [3:0]       match_idx_c;

    // Table lookup; scanning downwards lets the lowest matching index win
    always_comb begin
        match_hit_c = 1'b0;
        match_idx_c = 4'd0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (rx_data_i == KEY_TABLE[8*i +: 8]) begin
                match_hit_c = 1'b1;
                match_idx_c = 4'(i);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_index_q  <= 4'd0;
            rst_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_index_q  <= key_index_d;
            rst_req_q    <= rst_req_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        key_valid_d  = 1'b0;
        key_code_d   = 8'h00;
        key_index_d  = 4'd0;
        rst_req_d    = 1'b0;

        if (rx_done_tick_i) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data_i == BRK_CODE) begin
                        state_d = BRK;
                    end else if (rx_data_i == EXT_CODE) begin
                        state_d = EXT;
                    end else if (rx_data_i == RST_CODE) begin
                        // Reset key takes priority even if it also sits in the table
                        rst_req_d = 1'b1;
                    end else if (match_hit_c) begin
                        if (!(REPEAT_SUPPRESS && held_valid_q && (held_code_q == rx_data_i))) begin
                            key_valid_d  = 1'b1;
                            key_code_d   = rx_data_i;
                            key_index_d  = match_idx_c;
                            held_valid_d = 1'b1;
                            held_code_d  = rx_data_i;
                        end
                    end
                end
                BRK: begin
                    if (held_valid_q && (rx_data_i == held_code_q)) begin
                        held_valid_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                EXT: begin
                    state_d = (rx_data_i == BRK_CODE) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if ((state_q != IDLE) && (timer_q == TMR_LAST)) begin
            // Stale prefix: abandon it without touching the held key
            state_d = IDLE;
        end

        // Timer restarts on every state change and stays cleared in IDLE
        if ((state_d == IDLE) || (state_d != state_q)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign key_index_o = key_index_q;
    assign rst_req_o   = rst_req_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_filter
// Directed scenarios followed by random scancode streams. A reference model
// holds the pending prefix bytes in a queue and pushes expected pulses into a
// scoreboard; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_ps2_key_filter;

    localparam int unsigned N_KEYS  = 6;
    localparam logic [8*N_KEYS-1:0] KT = {8'h21, 8'h6C, 8'h73, 8'h7A, 8'h72, 8'h70};
    localparam logic [7:0] RSTC = 8'h2D;
    localparam logic [7:0] BRKC = 8'hF0;
    localparam logic [7:0] EXTC = 8'hE0;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       key_valid_o;
    logic [7:0] key_code_o;
    logic [3:0] key_index_o;
    logic       rst_req_o;

    ps2_key_filter #(
        .N_KEYS(N_KEYS), .KEY_TABLE(KT), .RST_CODE(RSTC), .BRK_CODE(BRKC),
        .EXT_CODE(EXTC), .REPEAT_SUPPRESS(1'b1), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_done_tick_i(rx_done_tick_i), .rx_data_i(rx_data_i),
        .key_valid_o(key_valid_o), .key_code_o(key_code_o), .key_index_o(key_index_o),
        .rst_req_o(rst_req_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    typedef struct {
        bit         is_rst;
        logic [7:0] code;
        int         idx;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] tbl [N_KEYS];
    logic [7:0] prefix[$];
    int         prefix_age;
    bit         held_valid;
    logic [7:0] held_code;

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < int'(N_KEYS); i++) if (tbl[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        prefix.delete();
        prefix_age = 0;
        held_valid = 1'b0;
        held_code  = 8'h00;
    endtask

    // One clock cycle of the reference model; the byte is sampled at the next edge
    task automatic model_step(input bit tick, input logic [7:0] b, input int due);
        exp_t e;
        int   idx;
        if (tick) begin
            prefix_age = 0;
            if (prefix.size() == 0) begin
                if (b == BRKC || b == EXTC) begin
                    prefix.push_back(b);
                end else if (b == RSTC) begin
                    e.is_rst = 1'b1; e.code = 8'h00; e.idx = 0; e.due = due;
                    exp_q.push_back(e);
                end else begin
                    idx = lookup(b);
                    if (idx >= 0 && !(held_valid && held_code == b)) begin
                        e.is_rst = 1'b0; e.code = b; e.idx = idx; e.due = due;
                        exp_q.push_back(e);
                        held_valid = 1'b1;
                        held_code  = b;
                    end
                end
            end else if (prefix.size() == 1 && prefix[0] == BRKC) begin
                if (held_valid && held_code == b) held_valid = 1'b0;
                prefix.delete();
            end else if (prefix.size() == 1 && b == BRKC) begin
                prefix.push_back(b);
            end else begin
                prefix.delete();
            end
        end else if (prefix.size() != 0) begin
            if (prefix_age == TOUT - 1) begin
                prefix.delete();
                prefix_age = 0;
            end else begin
                prefix_age++;
            end
        end
    endtask

    task automatic drive(input bit tick, input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done_tick_i = tick;
        rx_data_i      = tick ? b : 8'h00;
        model_step(tick, b, cyc + 1);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rx_done_tick_i = 1'b0;
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        #1;
        chk("rst_key_valid", int'(key_valid_o), 0);
        chk("rst_key_code",  int'(key_code_o), 0);
        chk("rst_key_index", int'(key_index_o), 0);
        chk("rst_rst_req",   int'(rst_req_o), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (key_valid_o || rst_req_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'({key_valid_o, rst_req_o}), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.due);
                    chk("key_valid", int'(key_valid_o), int'(!e.is_rst));
                    chk("rst_req",   int'(rst_req_o), int'(e.is_rst));
                    chk("key_code",  int'(key_code_o), e.is_rst ? 0 : int'(e.code));
                    chk("key_index", int'(key_index_o), e.is_rst ? 0 : e.idx);
                end
            end else begin
                chk("idle_code",  int'(key_code_o), 0);
                chk("idle_index", int'(key_index_o), 0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_pulse", 0, 1);
                end
            end
        end
    end

    function automatic logic [7:0] pick_byte();
        int r;
        r = int'($urandom_range(0, 11));
        if (r <= 4) return tbl[$urandom_range(0, N_KEYS - 1)];
        if (r == 5) return RSTC;
        if (r <= 7) return BRKC;
        if (r == 8) return EXTC;
        if (r == 9) return held_code;
        return 8'($urandom);
    endfunction

    initial begin
        logic [8*N_KEYS-1:0] kt_v;
        kt_v = KT;
        for (int i = 0; i < int'(N_KEYS); i++) tbl[i] = kt_v[8*i +: 8];
        model_reset();
        do_reset();

        // Basic make
        send(8'h70); idle(2);
        // Typematic suppression, then release and press again
        send(8'h7A); send(8'h7A); send(8'h7A); idle(1);
        send(BRKC); send(8'h7A); send(8'h7A); idle(2);
        // Reset key and an unmapped key
        send(RSTC); idle(1); send(8'h1C); idle(2);
        // Extended sequences are dropped; following make is accepted
        send(EXTC); send(8'h70); send(EXTC); send(BRKC); send(8'h70); idle(1);
        send(BRKC); send(8'h70); send(8'h70); idle(2);
        // Byte one cycle before expiry still counts as a break
        send(BRKC); idle(TOUT - 1); send(8'h70); send(8'h70); idle(2);
        // Full timeout: next byte is a make
        send(BRKC); idle(TOUT); send(8'h21); idle(2);
        // Reset mid-sequence clears held key
        send(8'h6C); idle(1); send(BRKC); do_reset(); send(8'h6C); idle(2);

        // Random streams with occasional long gaps and resets
        for (int n = 0; n < 3000; n++) begin
            send(pick_byte());
            if ($urandom_range(0, 15) == 0) idle(int'($urandom_range(TOUT - 2, TOUT + 1)));
            else idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 499) == 0) begin
                idle(2);
                do_reset();
            end
        end

        idle(4);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
